// File: rtl/wb_ram_burst_pkg.sv
// Shared Wishbone cycle-type / burst-type encodings and the slave FSM state type
// for the burst-capable Wishbone RAM.
package wb_ram_burst_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BURST  = 2'd2
    } state_t;

endpackage

// File: rtl/wb_ram_burst_adr_next.sv
// Predicts the word index of the next burst beat (linear or wrap-4/8/16) and
// reports whether the current and predicted indices fall inside the RAM.
module wb_burst_adr_next
    import wb_ram_burst_pkg::*;
#(
    parameter int IDX_W = 14,
    parameter int DEPTH = 1024
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic [1:0]       i_bte,
    output logic [IDX_W:0]   o_next,
    output logic             o_cur_in_range,
    output logic             o_next_in_range
);

    localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] M4  = (IDX_W+1)'(3);
    localparam logic [IDX_W:0] M8  = (IDX_W+1)'(7);
    localparam logic [IDX_W:0] M16 = (IDX_W+1)'(15);

    logic [IDX_W:0] w_cur;
    logic [IDX_W:0] w_inc;

    // One extra bit so a linear step past the top of the index space reads as out of range
    assign w_cur = {1'b0, i_idx};
    assign w_inc = w_cur + ONE;

    always_comb begin
        o_next = w_inc;
        case (i_bte)
            BTE_LINEAR: o_next = w_inc;
            BTE_WRAP4:  o_next = (w_cur & ~M4)  | (w_inc & M4);
            BTE_WRAP8:  o_next = (w_cur & ~M8)  | (w_inc & M8);
            BTE_WRAP16: o_next = (w_cur & ~M16) | (w_inc & M16);
            default:    o_next = w_inc;
        endcase
    end

    assign o_cur_in_range  = (64'(i_idx)  < 64'(DEPTH));
    assign o_next_in_range = (64'(o_next) < 64'(DEPTH));

endmodule

// File: rtl/wb_ram_burst.sv
// Wishbone B4 RAM slave with registered-feedback bursts: one wait state, then one beat per clock.
// Define WB_RAM_BURST_ERR_EN to answer out-of-range indices with err_o instead of ack_o.
module wb_ram_burst
    import wb_ram_burst_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH        = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    we_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o
);

`ifdef WB_RAM_BURST_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int SEL_BITS = $clog2(SELECT_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - SEL_BITS;
    localparam int MEM_AW   = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ack;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_dat;

    logic                  w_req;
    logic [IDX_W-1:0]      w_idx;
    logic [IDX_W:0]        w_next;
    logic                  w_cur_in;
    logic                  w_next_in;
    logic [IDX_W:0]        w_rd_idx;
    logic                  w_rd_ok;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_ack_nxt;
    logic                  w_err_nxt;
    logic                  w_load;
    logic                  w_wr_en;

    assign w_req = cyc_i & stb_i;
    assign w_idx = adr_i[ADDR_WIDTH-1:SEL_BITS];

    generate
        if (SEL_BITS > 0) begin : g_lsb
            logic w_unused_lsb;
            assign w_unused_lsb = ^adr_i[SEL_BITS-1:0];
        end
    endgenerate

    wb_burst_adr_next #(
        .IDX_W (IDX_W),
        .DEPTH (DEPTH)
    ) u_adr_next (
        .i_idx           (w_idx),
        .i_bte           (bte_i),
        .o_next          (w_next),
        .o_cur_in_range  (w_cur_in),
        .o_next_in_range (w_next_in)
    );

    // Inside a burst the registered read fetches the beat the master will present next
    assign w_rd_idx  = (r_state == ST_BURST) ? w_next    : {1'b0, w_idx};
    assign w_rd_ok   = (r_state == ST_BURST) ? w_next_in : w_cur_in;
    assign w_rd_data = w_rd_ok ? r_mem[MEM_AW'(w_rd_idx)] : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_load      = 1'b0;
        w_wr_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_load = 1'b1;
                    if (ERR_EN && !w_cur_in) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_SINGLE;
                    end else begin
                        w_ack_nxt = 1'b1;
                        case (cti_i)
                            CTI_INCR:                       w_state_nxt = ST_BURST;
                            CTI_CLASSIC, CTI_CONST, CTI_EOB: w_state_nxt = ST_SINGLE;
                            default:                        w_state_nxt = ST_SINGLE;
                        endcase
                    end
                end
            end
            ST_SINGLE: begin
                // An err beat completes here too but never writes
                w_state_nxt = ST_IDLE;
                w_wr_en     = w_req & r_ack & we_i & w_cur_in;
            end
            ST_BURST: begin
                if (w_req && r_ack) begin
                    w_wr_en = we_i & w_cur_in;
                    if (cti_i == CTI_EOB) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_load = 1'b1;
                        if (ERR_EN && !w_next_in) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_SINGLE;
                        end else begin
                            w_ack_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_dat <= w_err_nxt ? '0 : w_rd_data;
            end
        end
    end

    // Write enable is qualified by r_ack, which an asserted reset clears at once
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < SELECT_WIDTH; k++) begin
                if (sel_i[k]) begin
                    r_mem[MEM_AW'(w_idx)][8*k +: 8] <= dat_i[8*k +: 8];
                end
            end
        end
    end

    assign dat_o = r_dat;
    assign ack_o = r_ack;
    assign err_o = r_err;

endmodule

// File: tb/tb_wb_ram_burst.sv
// Randomised scoreboard bench for wb_ram_burst: a word-array reference model predicts each
// beat's response, a negedge monitor compares every completed beat against the queue.
module tb_wb_ram_burst;
    import wb_ram_burst_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int SW    = 4;
    localparam int DEPTH = 1024;
    localparam int MAW   = $clog2(DEPTH);

`ifdef WB_RAM_BURST_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr_i;
    logic [DW-1:0] dat_i;
    logic [DW-1:0] dat_o;
    logic          we_i;
    logic [SW-1:0] sel_i;
    logic          stb_i;
    logic          cyc_i;
    logic [2:0]    cti_i;
    logic [1:0]    bte_i;
    logic          ack_o;
    logic          err_o;

    typedef struct packed {
        logic          err;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] mon_last_dat = '0;
    int            n_cmp = 0;
    int            n_mis = 0;
    bit            mon_en = 1'b1;

    wb_ram_burst #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .SELECT_WIDTH (SW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .sel_i (sel_i),
        .stb_i (stb_i),
        .cyc_i (cyc_i),
        .cti_i (cti_i),
        .bte_i (bte_i),
        .ack_o (ack_o),
        .err_o (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary, required normal completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Word index of beat i of a burst, straight from the burst-type definition
    function automatic int beat_word(input int start, input int i, input logic [1:0] bte);
        int len;
        if (bte == BTE_LINEAR) return start + i;
        len = 4 << (int'(bte) - 1);
        return (start - (start % len)) + ((start % len) + i) % len;
    endfunction

    // Response of one beat against the current memory image, then apply its write
    function automatic exp_t model_beat(input int word, input logic we, input logic [DW-1:0] dat,
                                        input logic [SW-1:0] sel);
        exp_t e;
        bit   inr;
        inr   = (word < DEPTH);
        e.err = ERR_EN && !inr;
        e.dat = inr ? ref_mem[MAW'(word)] : '0;
        if (inr && we) begin
            for (int k = 0; k < SW; k++) begin
                if (sel[k]) ref_mem[MAW'(word)][8*k +: 8] = dat[8*k +: 8];
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst && cyc_i && stb_i && (ack_o || err_o)) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_mis++;
                $display("FAIL beat_unexpected: ack=%0b err=%0b dat=%h, required no response",
                         ack_o, err_o, dat_o);
            end else begin
                mon_e = exp_q.pop_front();
                mon_last_dat = dat_o;
                if (ack_o !== !mon_e.err || err_o !== mon_e.err || dat_o !== mon_e.dat) begin
                    n_mis++;
                    $display("FAIL beat_response @%h: ack=%0b err=%0b dat=%h, required ack=%0b err=%0b dat=%h",
                             adr_i, ack_o, err_o, dat_o, !mon_e.err, mon_e.err, mon_e.dat);
                end
            end
        end
    end

    task automatic release_bus();
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge on which the beat completed
    task automatic do_beat(input int word, input logic we, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel, input logic [2:0] cti, input logic [1:0] bte,
                           input int exp_wait, output bit got_err);
        int waits;
        waits = 0;
        adr_i = AW'(word * 4);
        we_i  = we;
        dat_i = dat;
        sel_i = sel;
        cti_i = cti;
        bte_i = bte;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        exp_q.push_back(model_beat(word, we, dat, sel));
        @(negedge clk);
        while (!(ack_o || err_o) && waits < 8) begin
            waits++;
            @(negedge clk);
        end
        if (!(ack_o || err_o)) begin
            check("beat_timeout", 32'(waits), 32'(exp_wait));
            void'(exp_q.pop_back());
            got_err = 1'b1;
        end else begin
            check("ack_latency", 32'(waits), 32'(exp_wait));
            got_err = err_o;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic classic(input int word, input logic we, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel, input bit hold);
        bit e;
        do_beat(word, we, dat, sel, ($urandom_range(0, 1) == 1) ? CTI_CONST : CTI_CLASSIC,
                2'($urandom_range(0, 3)), 1, e);
        if (!hold) release_bus();
    endtask

    task automatic burst(input int start, input int n, input logic [1:0] bte, input logic we,
                         input int drop_at, input bit rnd, input logic [DW-1:0] base,
                         input logic [SW-1:0] sel);
        bit            e;
        int            w;
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            w = beat_word(start, i, bte);
            d = rnd ? DW'($urandom) : base + DW'(i);
            if (i == drop_at && i > 0) begin
                stb_i = 1'b0;
                @(posedge clk);
                #1;
            end
            do_beat(w, we, d, sel, (i == n - 1) ? CTI_EOB : CTI_INCR, bte,
                    (i == 0 || i == drop_at) ? 1 : 0, e);
            if (e) break;
        end
        release_bus();
    endtask

    initial begin : main
        int            kind;
        int            w;
        int            n;
        int            dr;
        bit            e;
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;

        rst = 1'b1;
        adr_i = '0; dat_i = '0; sel_i = '0; cti_i = '0; bte_i = '0;
        release_bus();
        for (int i = 0; i < DEPTH; i++) ref_mem[MAW'(i)] = '0;
        idle(3);
        check("reset_ack", 32'(ack_o), 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_dat", dat_o, 32'd0);
        rst = 1'b0;
        idle(1);

        // Preload word i = i over words 0..15
        burst(0, 16, BTE_LINEAR, 1'b1, -1, 1'b0, 32'd0, 4'hF);
        idle(1);

        // Back-to-back classic write then read with the strobe held
        classic(4, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1);
        classic(4, 1'b0, 32'h0, 4'hF, 1'b0);
        check("classic_read", mon_last_dat, 32'hDEADBEEF);
        classic(4, 1'b1, 32'h000000AA, 4'b0001, 1'b0);
        classic(4, 1'b0, 32'h0, 4'hF, 1'b0);
        check("byte_lane_read", mon_last_dat, 32'hDEADBEAA);
        idle(1);

        burst(0, 4, BTE_LINEAR, 1'b0, -1, 1'b0, 32'd0, 4'hF);
        check("linear_read_last", mon_last_dat, 32'd3);
        idle(2);

        // Wrap-4 write from word 6 touches 6,7,4,5 only
        burst(6, 4, BTE_WRAP4, 1'b1, -1, 1'b0, 32'hA0, 4'hF);
        classic(4, 1'b0, 32'h0, 4'hF, 1'b0);
        check("wrap4_word4", mon_last_dat, 32'hA2);
        classic(6, 1'b0, 32'h0, 4'hF, 1'b0);
        check("wrap4_word6", mon_last_dat, 32'hA0);
        classic(8, 1'b0, 32'h0, 4'hF, 1'b0);
        check("wrap4_word8", mon_last_dat, 32'd8);
        idle(1);

        // Strobe dropped for one cycle mid-burst, then read back
        burst(32, 6, BTE_LINEAR, 1'b1, 3, 1'b1, 32'd0, 4'hF);
        idle(1);
        burst(32, 6, BTE_LINEAR, 1'b0, -1, 1'b0, 32'd0, 4'hF);
        idle(2);

        // Reset during the third beat of a write burst over words 8..10
        r0 = DW'($urandom) | 32'h1;
        r1 = DW'($urandom) | 32'h1;
        r2 = DW'($urandom) | 32'h1;
        do_beat(8, 1'b1, r0, 4'hF, CTI_INCR, BTE_LINEAR, 1, e);
        do_beat(9, 1'b1, r1, 4'hF, CTI_INCR, BTE_LINEAR, 0, e);
        mon_en = 1'b0;
        adr_i = AW'(10 * 4);
        dat_i = r2;
        @(negedge clk);
        check("abort_beat_ack", 32'(ack_o), 32'd1);
        rst = 1'b1;
        #1;
        check("midburst_rst_ack", 32'(ack_o), 32'd0);
        check("midburst_rst_err", 32'(err_o), 32'd0);
        check("midburst_rst_dat", dat_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        release_bus();
        mon_en = 1'b1;
        idle(2);
        burst(8, 4, BTE_LINEAR, 1'b0, -1, 1'b0, 32'd0, 4'hF);
        idle(1);

        // Out-of-range index: ack with zero data, or err when the error response is built in
        classic(DEPTH, 1'b0, 32'h0, 4'hF, 1'b0);
        idle(1);
        burst(DEPTH - 1, 4, BTE_LINEAR, 1'b0, -1, 1'b0, 32'd0, 4'hF);
        idle(2);

        for (int t = 0; t < 60; t++) begin
            kind = int'($urandom_range(0, 2));
            w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH - 4, DEPTH + 4))
                                            : int'($urandom_range(0, 63));
            if (kind == 0) begin
                classic(w, $urandom_range(0, 1) == 1, DW'($urandom), 4'($urandom_range(0, 15)),
                        $urandom_range(0, 1) == 1);
            end else begin
                n  = int'($urandom_range(1, 8));
                dr = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : -1;
                burst(w, n, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, dr, 1'b1, 32'd0,
                      4'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 1) == 1) begin
                release_bus();
                idle(int'($urandom_range(1, 2)));
            end
        end
        release_bus();
        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wb_ram_burst.md
# wb_ram_burst

Wishbone B4 single-port RAM slave with registered-feedback burst support: incrementing and wrapping bursts (CTI/BTE) complete one beat per clock after a single initial wait state. Classic single cycles complete in two clocks. It replaces the plain Wishbone RAM on the SoC interconnect wherever the MIPS32 instruction fetch or a DMA master issues burst cycles. Byte-lane writes, a parametrised depth independent of the address width, and an optional bus-error response for out-of-range addresses.

## Interface
- DATA_WIDTH, 32, data bus width in bits (8/16/32/64)
- ADDR_WIDTH, 16, byte address width
- SELECT_WIDTH, DATA_WIDTH/8, byte-lane select width
- DEPTH, 1024, number of DATA_WIDTH words (any value ≥ 2; need not be a power of two)
- clk  input  1  sole clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- adr_i  input  ADDR_WIDTH  byte address; word index = adr_i >> log2(SELECT_WIDTH)
- dat_i  input  DATA_WIDTH  write data
- dat_o  output  DATA_WIDTH  registered read data
- we_i  input  1  write enable
- sel_i  input  SELECT_WIDTH  byte-lane select
- stb_i  input  1  strobe
- cyc_i  input  1  cycle valid
- cti_i  input  3  cycle type: 000 classic, 001 const-address (treated as classic), 010 incrementing burst, 111 end-of-burst
- bte_i  input  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16 (word units)
- ack_o  output  1  registered acknowledge
- err_o  output  1  registered bus error (constant 0 unless WB_RAM_BURST_ERR_EN)

## Operation
- Request = cyc_i & stb_i. A beat completes on the rising edge where request & (ack_o | err_o).
- Writes occur only on the completing edge, at the word index of adr_i, per lane where sel_i[k]; never during the wait state.
- FSM states: IDLE, SINGLE, BURST.
- IDLE, request: dat_o <= mem[idx(adr_i)], ack_o <= 1. Next state BURST if cti_i==010, otherwise SINGLE.
- SINGLE: ack_o <= 0, return to IDLE. This guarantees one dead cycle between classic beats.
- BURST on a completing edge:
  - cti_i==111: ack_o <= 0, go to IDLE.
  - Otherwise: dat_o <= mem[next(idx)], ack_o <= 1, stay in BURST.
- BURST with stb_i low or cyc_i low: ack_o <= 0, go to IDLE. A resumed strobe restarts with a wait state.
- next(idx): linear = idx+1; wrap-N = upper bits kept, low log2(N) bits incremented mod N.
- The read of next(idx) and the write of idx on the same edge never collide. dat_o reflects memory before that edge's write.
- Out-of-range index (≥ DEPTH), without the macro: read returns 0, write dropped, ack normal.
- Reset: ack_o=0, err_o=0, dat_o=0, state IDLE. Memory is not cleared (initialised to 0 at elaboration). Writes completed before reset persist; no partial write occurs.

## Timing
- Classic read/write: request at cycle t, ack_o high in cycle t+1, low in t+2. Two clocks per beat.
- Burst of N beats: first ack at t+1, then acks in t+2 … t+N, ack_o low in t+N+1. N+1 clocks total.
- dat_o is valid exactly while ack_o is high; it holds its last value otherwise.
- ack_o and err_o are never high together and are never high without a request in the previous cycle.

## Configuration
- WB_RAM_BURST_ERR_EN defined: an out-of-range index (initial or predicted next beat) asserts err_o instead of ack_o for that beat, with no write and dat_o = 0. After err_o the FSM goes to SINGLE, which terminates any burst.
- Undefined: err_o tied 0; out-of-range behaviour as in Operation.

## Structure
- Package wb_ram_burst_pkg holds:
  - CTI constants (CTI_CLASSIC, CTI_CONST, CTI_INCR, CTI_EOB)
  - BTE constants (BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16)
  - FSM state enum
- Sub-module wb_burst_adr_next computes next(idx) and the in-range flag from idx and bte_i.

## Test plan
- Classic write 0xDEADBEEF to 0x0010 with sel 1111, then classic read of 0x0010 → ack one cycle after each strobe, dat_o=0xDEADBEEF, one dead cycle between beats.
- Byte-lane write 0x000000AA to 0x0010 with sel 0001 → read returns 0xDEADBEAA.
- Linear read burst of 4 beats from 0x0000 (memory preloaded word i = i), cti 010,010,010,111 → acks in 4 consecutive cycles after one wait state, dat_o = 0,1,2,3, then ack low.
- Wrap-4 write burst starting at word 6, data A,B,C,D → words 6,7,4,5 hold A,B,C,D and word 8 is unchanged.
- Master drops stb_i for one cycle mid-burst → ack_o low that cycle, one wait state on resume, no lost or duplicated write.
- With WB_RAM_BURST_ERR_EN, DEPTH=1024: read at word 1024 → err_o pulse, ack_o 0. Linear burst from word 1023 → ack for word 1023, then err for word 1024, after which the burst is terminated. Assert rst mid-burst → ack_o, err_o and dat_o go to 0 immediately.
